// File: rtl/stopwatch_lap.sv
// Up/down hh:mm:ss.cc stopwatch driven by a clock-enable tick, with sticky
// overflow/expiry flags and a first-word-fall-through lap-capture FIFO.
module stopwatch_lap #(
    parameter int CLK_HZ    = 50000000,
    parameter int TICK_HZ   = 100,
    parameter int HOUR_MAX  = 24,
    parameter int LAP_DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         run,
    input  logic                         clear,
    input  logic                         load,
    input  logic                         mode_down,
    input  logic [5:0]                   load_hour,
    input  logic [5:0]                   load_minute,
    input  logic [5:0]                   load_second,
    input  logic [6:0]                   load_msec,
    input  logic                         lap,
    input  logic                         lap_rd,
    output logic [5:0]                   hour,
    output logic [5:0]                   minute,
    output logic [5:0]                   second,
    output logic [6:0]                   m_sec,
    output logic                         overflow,
    output logic                         expired,
    output logic                         lap_valid,
    output logic                         lap_full,
    output logic                         lap_lost,
    output logic [$clog2(LAP_DEPTH):0]   lap_count,
    output logic [24:0]                  lap_time
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int DIV_W = $clog2(DIV);
    localparam int PTR_W = $clog2(LAP_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [DIV_W-1:0] DIV_TOP  = DIV_W'(DIV - 1);
    localparam logic [5:0]       HOUR_TOP = 6'(HOUR_MAX - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(LAP_DEPTH);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    logic [5:0] up_hour, up_min, up_sec;
    logic [6:0] up_msec;
    logic       up_wrap;
    logic [5:0] dn_hour, dn_min, dn_sec;
    logic [6:0] dn_msec;
    logic       at_zero;
    logic       dn_zero;

    logic [24:0]      lap_mem [LAP_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    assign tick = run && (div_cnt == DIV_TOP);

    always_ff @(posedge clock) begin
        if (reset || clear || load) begin
            div_cnt <= '0;
        end else if (run) begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
        end
    end

    // Up-count successor: every carry resolves combinationally, so the
    // registers never hold 100 centiseconds or 60 seconds/minutes.
    always_comb begin
        up_hour = hour;
        up_min  = minute;
        up_sec  = second;
        up_msec = m_sec;
        up_wrap = 1'b0;
        if (m_sec == 7'd99) begin
            up_msec = 7'd0;
            if (second == 6'd59) begin
                up_sec = 6'd0;
                if (minute == 6'd59) begin
                    up_min = 6'd0;
                    if (hour == HOUR_TOP) begin
                        up_hour = 6'd0;
                        up_wrap = 1'b1;
                    end else begin
                        up_hour = hour + 6'd1;
                    end
                end else begin
                    up_min = minute + 6'd1;
                end
            end else begin
                up_sec = second + 6'd1;
            end
        end else begin
            up_msec = m_sec + 7'd1;
        end
    end

    always_comb begin
        at_zero = (hour == 6'd0) && (minute == 6'd0) && (second == 6'd0) && (m_sec == 7'd0);
        dn_hour = hour;
        dn_min  = minute;
        dn_sec  = second;
        dn_msec = m_sec;
        if (!at_zero) begin
            if (m_sec == 7'd0) begin
                dn_msec = 7'd99;
                if (second == 6'd0) begin
                    dn_sec = 6'd59;
                    if (minute == 6'd0) begin
                        dn_min  = 6'd59;
                        dn_hour = hour - 6'd1;
                    end else begin
                        dn_min = minute - 6'd1;
                    end
                end else begin
                    dn_sec = second - 6'd1;
                end
            end else begin
                dn_msec = m_sec - 7'd1;
            end
        end
        dn_zero = (dn_hour == 6'd0) && (dn_min == 6'd0) && (dn_sec == 6'd0) && (dn_msec == 7'd0);
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            hour     <= '0;
            minute   <= '0;
            second   <= '0;
            m_sec    <= '0;
            overflow <= 1'b0;
            expired  <= 1'b0;
        end else if (load) begin
            hour     <= (load_hour > HOUR_TOP) ? HOUR_TOP : load_hour;
            minute   <= (load_minute > 6'd59) ? 6'd59 : load_minute;
            second   <= (load_second > 6'd59) ? 6'd59 : load_second;
            m_sec    <= (load_msec > 7'd99) ? 7'd99 : load_msec;
            overflow <= 1'b0;
            expired  <= 1'b0;
        end else if (tick) begin
            if (mode_down) begin
                hour   <= dn_hour;
                minute <= dn_min;
                second <= dn_sec;
                m_sec  <= dn_msec;
                if (dn_zero) begin
                    expired <= 1'b1;
                end
            end else begin
                hour   <= up_hour;
                minute <= up_min;
                second <= up_sec;
                m_sec  <= up_msec;
                if (up_wrap) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    // Lap handshake: lap is a push request accepted when the FIFO has room
    // or a pop happens in the same cycle; lap_rd pops only while lap_valid=1.
    assign pop  = !clear && lap_rd && lap_valid;
    assign push = !clear && lap && (!lap_full || pop);

    always_ff @(posedge clock) begin
        if (push) begin
            lap_mem[wr_ptr] <= {hour, minute, second, m_sec};
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            lap_count <= '0;
            lap_lost  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                lap_count <= lap_count + CNT_W'(1);
            end else if (pop && !push) begin
                lap_count <= lap_count - CNT_W'(1);
            end
            if (lap && lap_full && !pop) begin
                lap_lost <= 1'b1;
            end
        end
    end

    assign lap_valid = (lap_count != '0);
    assign lap_full  = (lap_count == DEPTH_C);
    assign lap_time  = lap_mem[rd_ptr];

endmodule

// File: tb/tb_stopwatch_lap.sv
// Randomised and directed bench for stopwatch_lap against a model that keeps
// time as a single centisecond count and the lap FIFO as a queue.
module tb_stopwatch_lap;

    localparam int CLK_HZ    = 1000;
    localparam int TICK_HZ   = 100;
    localparam int HOUR_MAX  = 2;
    localparam int LAP_DEPTH = 4;
    localparam int DIV       = CLK_HZ / TICK_HZ;
    localparam int MAX_CS    = HOUR_MAX * 360000;

    logic        clock;
    logic        reset;
    logic        run;
    logic        clear;
    logic        load;
    logic        mode_down;
    logic [5:0]  load_hour;
    logic [5:0]  load_minute;
    logic [5:0]  load_second;
    logic [6:0]  load_msec;
    logic        lap;
    logic        lap_rd;
    logic [5:0]  hour;
    logic [5:0]  minute;
    logic [5:0]  second;
    logic [6:0]  m_sec;
    logic        overflow;
    logic        expired;
    logic        lap_valid;
    logic        lap_full;
    logic        lap_lost;
    logic [2:0]  lap_count;
    logic [24:0] lap_time;

    stopwatch_lap #(
        .CLK_HZ   (CLK_HZ),
        .TICK_HZ  (TICK_HZ),
        .HOUR_MAX (HOUR_MAX),
        .LAP_DEPTH(LAP_DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .run        (run),
        .clear      (clear),
        .load       (load),
        .mode_down  (mode_down),
        .load_hour  (load_hour),
        .load_minute(load_minute),
        .load_second(load_second),
        .load_msec  (load_msec),
        .lap        (lap),
        .lap_rd     (lap_rd),
        .hour       (hour),
        .minute     (minute),
        .second     (second),
        .m_sec      (m_sec),
        .overflow   (overflow),
        .expired    (expired),
        .lap_valid  (lap_valid),
        .lap_full   (lap_full),
        .lap_lost   (lap_lost),
        .lap_count  (lap_count),
        .lap_time   (lap_time)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // scoreboard and reference model state
    int          n_cmp  = 0;
    int          n_err  = 0;
    logic [24:0] exp_q[$];
    int          m_cs   = 0;
    int          m_div  = 0;
    bit          m_ovf  = 0;
    bit          m_exp  = 0;
    bit          m_lost = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [24:0] fields(input int cs);
        fields = {6'(cs / 360000), 6'((cs / 6000) % 60), 6'((cs / 100) % 60), 7'(cs % 100)};
    endfunction

    function automatic int sat(input int v, input int top);
        sat = (v > top) ? top : v;
    endfunction

    task automatic model_step();
        logic [24:0] snap;
        snap = fields(m_cs);
        if (reset || clear) begin
            m_cs   = 0;
            m_div  = 0;
            m_ovf  = 0;
            m_exp  = 0;
            m_lost = 0;
            exp_q.delete();
        end else begin
            if (lap_rd && exp_q.size() > 0) void'(exp_q.pop_front());
            if (lap) begin
                if (exp_q.size() < LAP_DEPTH) exp_q.push_back(snap);
                else m_lost = 1;
            end
            if (load) begin
                m_cs  = sat(load_hour, HOUR_MAX - 1) * 360000 + sat(load_minute, 59) * 6000
                      + sat(load_second, 59) * 100 + sat(load_msec, 99);
                m_div = 0;
                m_ovf = 0;
                m_exp = 0;
            end else if (run) begin
                if (m_div == DIV - 1) begin
                    m_div = 0;
                    if (mode_down) begin
                        if (m_cs > 0) m_cs--;
                        if (m_cs == 0) m_exp = 1;
                    end else if (m_cs == MAX_CS - 1) begin
                        m_cs  = 0;
                        m_ovf = 1;
                    end else begin
                        m_cs++;
                    end
                end else begin
                    m_div++;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [24:0] t;
        t = fields(m_cs);
        check("hour", hour, t[24:19]);
        check("minute", minute, t[18:13]);
        check("second", second, t[12:7]);
        check("m_sec", m_sec, t[6:0]);
        check("overflow", overflow, m_ovf);
        check("expired", expired, m_exp);
        check("lap_lost", lap_lost, m_lost);
        check("lap_count", lap_count, exp_q.size());
        check("lap_valid", lap_valid, exp_q.size() > 0);
        check("lap_full", lap_full, exp_q.size() == LAP_DEPTH);
        if (exp_q.size() > 0) check("lap_time", lap_time, exp_q[0]);
    endtask

    // driver: one clock per iteration, pulses auto-drop after their cycle
    task automatic step(input int n);
        repeat (n) begin
            model_step();
            @(posedge clock);
            #1;
            compare_all();
            lap    = 1'b0;
            lap_rd = 1'b0;
            clear  = 1'b0;
            load   = 1'b0;
        end
    endtask

    task automatic do_load(input int h, input int m, input int s, input int c);
        load_hour   = 6'(h);
        load_minute = 6'(m);
        load_second = 6'(s);
        load_msec   = 7'(c);
        load        = 1'b1;
        step(1);
    endtask

    logic [24:0] last_exp;

    initial begin
        reset = 1'b1; run = 1'b0; clear = 1'b0; load = 1'b0; mode_down = 1'b0;
        load_hour = '0; load_minute = '0; load_second = '0; load_msec = '0;
        lap = 1'b0; lap_rd = 1'b0;
        step(2);
        reset = 1'b0;
        check("rst_time", {hour, minute, second, m_sec}, 0);
        check("rst_count", lap_count, 0);

        // run, pause mid-interval, resume
        run = 1'b1; step(100);
        check("run100_msec", m_sec, 10);
        step(4);
        run = 1'b0; step(37);
        check("pause_msec", m_sec, 10);
        run = 1'b1; step(5);
        check("resume_early", m_sec, 10);
        step(1);
        check("resume_tick", m_sec, 11);

        // up-count wrap at maximum time
        do_load(1, 59, 59, 98);
        step(10);
        check("pre_wrap", {hour, minute, second, m_sec}, {6'd1, 6'd59, 6'd59, 7'd99});
        check("pre_wrap_ovf", overflow, 0);
        step(10);
        check("wrap_time", {hour, minute, second, m_sec}, 0);
        check("wrap_ovf", overflow, 1);

        // down-count to expiry and hold
        clear = 1'b1; step(1);
        mode_down = 1'b1;
        do_load(0, 0, 1, 1);
        step(1000);
        check("dn_100", m_sec, 1);
        check("dn_100_exp", expired, 0);
        step(10);
        check("dn_zero", {hour, minute, second, m_sec}, 0);
        check("dn_exp", expired, 1);
        step(500);
        check("dn_hold", {hour, minute, second, m_sec}, 0);
        check("dn_hold_exp", expired, 1);
        clear = 1'b1; step(1);
        check("clr_exp", expired, 0);

        // five laps into a four-deep FIFO
        mode_down = 1'b0;
        repeat (5) begin
            step(23);
            lap = 1'b1; step(1);
        end
        check("laps_full", lap_full, 1);
        check("laps_lost", lap_lost, 1);
        check("lap1_time", lap_time, 25'd2);
        for (int i = 0; i < 4; i++) begin
            lap_rd = 1'b1; step(1);
        end
        check("drained", lap_count, 0);
        lap_rd = 1'b1; step(1);
        check("rd_empty", lap_count, 0);

        // lap coincident with tick, then push+pop while full
        clear = 1'b1; step(1);
        step(99);
        lap = 1'b1; step(1);
        check("lap_on_tick", lap_time, 25'd9);
        check("tick_after_lap", m_sec, 10);
        repeat (3) begin
            step(5);
            lap = 1'b1; step(1);
        end
        check("full_again", lap_full, 1);
        step(3);
        last_exp = fields(m_cs);
        lap = 1'b1; lap_rd = 1'b1; step(1);
        check("pushpop_count", lap_count, 4);
        check("pushpop_lost", lap_lost, 0);
        for (int i = 0; i < 3; i++) begin
            lap_rd = 1'b1; step(1);
        end
        check("pushpop_last", lap_time, last_exp);

        // reset dominates load and lap
        step(37);
        reset = 1'b1; load = 1'b1; lap = 1'b1; load_hour = 6'd1; step(1);
        check("rst_mid_time", {hour, minute, second, m_sec}, 0);
        check("rst_mid_count", lap_count, 0);
        check("rst_mid_valid", lap_valid, 0);
        reset = 1'b0;

        // random phase
        for (int i = 0; i < 6000; i++) begin
            run    = ($urandom_range(0, 9) != 0);
            lap    = ($urandom_range(0, 19) == 0);
            lap_rd = ($urandom_range(0, 24) == 0);
            clear  = ($urandom_range(0, 399) == 0);
            reset  = ($urandom_range(0, 1499) == 0);
            if ($urandom_range(0, 199) == 0) mode_down = ~mode_down;
            if ($urandom_range(0, 149) == 0) begin
                load = 1'b1;
                if ($urandom_range(0, 1) == 0) begin
                    load_hour   = 6'(mode_down ? 0 : 1);
                    load_minute = mode_down ? 6'd0 : 6'd59;
                    load_second = mode_down ? 6'd0 : 6'd59;
                    load_msec   = 7'($urandom_range(mode_down ? 0 : 90, mode_down ? 20 : 127));
                end else begin
                    load_hour   = 6'($urandom_range(0, 63));
                    load_minute = 6'($urandom_range(0, 63));
                    load_second = 6'($urandom_range(0, 63));
                    load_msec   = 7'($urandom_range(0, 127));
                end
            end
            step(1);
            reset = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
